rca_seq_ctrl: RTL and testbench



---
 rtl/rca_seq_ctrl_if.sv | 33 +++
 rtl/rca_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rca_seq_ctrl_if.sv
// Requester-side bus of rca_seq_ctrl: operand request, status and assembled result.
// With RCA_SEQ_CTRL_SUB_EN defined the bus also carries the subtract select.
interface rca_seq_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_in;
`ifdef RCA_SEQ_CTRL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout_out;

  modport master (
    output start, op_a, op_b, cin_in,
`ifdef RCA_SEQ_CTRL_SUB_EN
    output sub,
`endif
    input  busy, done, result, cout_out
  );

  modport slave (
    input  start, op_a, op_b, cin_in,
`ifdef RCA_SEQ_CTRL_SUB_EN
    input  sub,
`endif
    output busy, done, result, cout_out
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Wide adder built by sequencing one shared 4-bit ripple-carry slice, LSB nibble first.
// Optional subtract mode (A - B) is enabled by defining RCA_SEQ_CTRL_SUB_EN.
module rca_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  rca_seq_ctrl_if.slave      bus,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
  input  logic               add_cout
);
  localparam int W  = 4 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   sum_r;
  logic           fc_r;
  logic [IW-1:0]  idx_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   result_r;
  logic           cout_r;
  logic [3:0]     add_a_r;
  logic [3:0]     add_b_r;
  logic           add_cin_r;

  logic [W-1:0]   b_in_s;
  logic           c0_s;
  logic           accept_s;
  logic [IW:0]    nidx_s;

  function automatic logic [3:0] nibble(input logic [W-1:0] v, input logic [IW:0] i);
    logic [W-1:0] t;
    t = v >> {i, 2'b00};
    return t[3:0];
  endfunction

  // Operand B and initial carry as they are to be latched (inverted B, carry 1 when subtracting)
  always_comb begin
    b_in_s = bus.op_b;
    c0_s   = bus.cin_in;
`ifdef RCA_SEQ_CTRL_SUB_EN
    if (bus.sub) begin
      b_in_s = ~bus.op_b;
      c0_s   = 1'b1;
    end else begin
      b_in_s = bus.op_b;
      c0_s   = bus.cin_in;
    end
`endif
  end

  assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign nidx_s   = {1'b0, idx_r} + (IW + 1)'(1);

  // Sequencer FSM; adder drive is registered so each RUN cycle presents nibble idx_r.
  // The result is published one edge after the last nibble, so it is stable under done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      fc_r      <= 1'b0;
      idx_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
      cout_r    <= 1'b0;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
      add_cin_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            result_r <= '0;
            cout_r   <= 1'b0;
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= add_sum;
          if (idx_r == LAST_IDX) begin
            fc_r      <= add_cout;
            busy_r    <= 1'b0;
            add_a_r   <= 4'h0;
            add_b_r   <= 4'h0;
            add_cin_r <= 1'b0;
            state_r   <= DONE;
          end else begin
            idx_r     <= idx_r + IW'(1);
            add_a_r   <= nibble(a_r, nidx_s);
            add_b_r   <= nibble(b_r, nidx_s);
            add_cin_r <= add_cout;
            state_r   <= RUN;
          end
        end
        DONE: begin
          result_r <= sum_r;
          cout_r   <= fc_r;
          done_r   <= 1'b1;
          state_r  <= bus.start ? RUN : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      if (accept_s) begin
        a_r       <= bus.op_a;
        b_r       <= b_in_s;
        sum_r     <= '0;
        idx_r     <= '0;
        busy_r    <= 1'b1;
        add_a_r   <= bus.op_a[3:0];
        add_b_r   <= b_in_s[3:0];
        add_cin_r <= c0_s;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.cout_out = cout_r;
  assign add_a        = add_a_r;
  assign add_b        = add_b_r;
  assign add_cin      = add_cin_r;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WORDS=4); models the shared 4-bit adder slice.
// Subtract vectors run when RCA_SEQ_CTRL_SUB_EN is defined.
module tb_rca_seq_ctrl;
  logic       clk;
  logic       rst;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;
  int         n_cmp;
  int         n_bad;
  int         k;
  int         done_seen;

  rca_seq_ctrl_if #(.W(16)) bus ();

  rca_seq_ctrl #(.WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Steps until done is seen (at most 12 cycles); k is the number of edges taken
  task automatic wait_done(input string tag);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.done === 1'b1) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.op_a   = a;
    bus.op_b   = b;
    bus.cin_in = c;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    drive(16'h0, 16'h0, 1'b0);
`ifdef RCA_SEQ_CTRL_SUB_EN
    bus.sub = 1'b0;
`endif
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout_out}, 32'd0);
    chk("rst_add_a", {28'd0, add_a}, 32'd0);
    chk("rst_add_b", {28'd0, add_b}, 32'd0);
    chk("rst_add_cin", {31'd0, add_cin}, 32'd0);
    rst = 1'b0;
    step();

    // 0x1234 + 0x4321 + 1
    drive(16'h1234, 16'h4321, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    chk("t1_add_a0", {28'd0, add_a}, 32'h4);
    wait_done("t1");
    chk("t1_latency", k, 32'd5);
    chk("t1_result", {16'd0, bus.result}, 32'h5556);
    chk("t1_cout", {31'd0, bus.cout_out}, 32'd0);
    step();
    chk("t1_done_pulse", {31'd0, bus.done}, 32'd0);

    // 0xFFFF + 0x0001: carry ripples through every nibble
    drive(16'hFFFF, 16'h0001, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t2_cin0", {31'd0, add_cin}, 32'd0);
    step();
    chk("t2_cin1", {31'd0, add_cin}, 32'd1);
    step();
    chk("t2_cin2", {31'd0, add_cin}, 32'd1);
    step();
    chk("t2_cin3", {31'd0, add_cin}, 32'd1);
    step();
    chk("t2_early_done", {31'd0, bus.done}, 32'd0);
    step();
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_result", {16'd0, bus.result}, 32'h0000);
    chk("t2_cout", {31'd0, bus.cout_out}, 32'd1);
    step();

    // 0x0001 + 0x000F with a start pulsed mid-RUN that must be ignored
    drive(16'h0001, 16'h000F, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    drive(16'hAAAA, 16'h000F, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("t3");
    chk("t3_latency_rest", k, 32'd3);
    chk("t3_result", {16'd0, bus.result}, 32'h0010);
    chk("t3_cout", {31'd0, bus.cout_out}, 32'd0);
    step();
    chk("t3_no_requeue", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with start held high
    drive(16'h0F0F, 16'h00F1, 1'b0);
    bus.start = 1'b1;
    step();
    drive(16'h8000, 16'h8000, 1'b0);
    wait_done("t4a");
    bus.start = 1'b0;
    chk("t4a_latency", k, 32'd5);
    chk("t4a_result", {16'd0, bus.result}, 32'h1000);
    chk("t4a_cout", {31'd0, bus.cout_out}, 32'd0);
    chk("t4a_busy_again", {31'd0, bus.busy}, 32'd1);
    wait_done("t4b");
    chk("t4b_spacing", k, 32'd5);
    chk("t4b_result", {16'd0, bus.result}, 32'h0000);
    chk("t4b_cout", {31'd0, bus.cout_out}, 32'd1);
    step();

    // Reset during the second RUN cycle abandons the operation
    drive(16'h1234, 16'h4321, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_result", {16'd0, bus.result}, 32'd0);
    chk("t5_add_a", {28'd0, add_a}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1) done_seen++;
    end
    chk("t5_no_done", done_seen, 32'd0);
    drive(16'h0F0F, 16'h00F1, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("t5b");
    chk("t5b_latency", k, 32'd5);
    chk("t5b_result", {16'd0, bus.result}, 32'h1000);
    step();

`ifdef RCA_SEQ_CTRL_SUB_EN
    // 5 - 7 borrows, 7 - 5 does not
    drive(16'h0005, 16'h0007, 1'b0);
    bus.sub = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("s1");
    chk("s1_result", {16'd0, bus.result}, 32'hFFFE);
    chk("s1_cout", {31'd0, bus.cout_out}, 32'd0);
    step();
    drive(16'h0007, 16'h0005, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("s2");
    chk("s2_result", {16'd0, bus.result}, 32'h0002);
    chk("s2_cout", {31'd0, bus.cout_out}, 32'd1);
    bus.sub = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
